// File: rtl/mod_counter.sv
// Up/down modulo counter with parallel load, wrap or saturate at the range limits,
// a combinational terminal-count output for cascading and a sticky limit-event flag.
module mod_counter #(
   parameter int unsigned WIDTH    = 6,
   parameter int unsigned MODULUS  = 64,
   parameter int unsigned SATURATE = 0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Load,
   input  logic             Up,
   input  logic [WIDTH-1:0] Data,
   input  logic             ClearFlag,
   output logic [WIDTH-1:0] Count,
   output logic             TermCount,
   output logic             Rollover
);

   if (WIDTH < 2 || WIDTH > 31) begin : gen_bad_width
      $error("mod_counter: WIDTH must be in 2..31");
   end
   if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : gen_bad_modulus
      $error("mod_counter: MODULUS must be in 2..2**WIDTH");
   end
   if (SATURATE > 1) begin : gen_bad_saturate
      $error("mod_counter: SATURATE must be 0 or 1");
   end

   localparam logic [WIDTH:0]   ModExt = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
   localparam bit               Sat    = (SATURATE != 0);

   logic [WIDTH-1:0] count_q, count_d;
   logic             rollover_q, rollover_d;
   logic             at_top, at_bot, limit;

   assign at_top = (count_q == MaxVal);
   assign at_bot = (count_q == '0);
   assign limit  = Enable & ~Load & ((Up & at_top) | (~Up & at_bot));

   always_comb begin
      count_d    = count_q;
      rollover_d = rollover_q;
      if (Load) begin
         // Out-of-range load values clamp to the top of the range.
         count_d = ({1'b0, Data} < ModExt) ? Data : MaxVal;
      end else begin
         if (Enable) begin
            if (Up) begin
               if (at_top) count_d = Sat ? MaxVal : '0;
               else        count_d = count_q + 1'b1;
            end else begin
               if (at_bot) count_d = Sat ? '0 : MaxVal;
               else        count_d = count_q - 1'b1;
            end
         end
         if (limit)          rollover_d = 1'b1;
         else if (ClearFlag) rollover_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q    <= '0;
         rollover_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         rollover_q <= rollover_d;
      end
   end

   assign Count     = count_q;
   assign Rollover  = rollover_q;
   assign TermCount = limit & ~Reset;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a wrapping and a saturating instance share stimulus;
// a behavioural model pushes expected results into a scoreboard queue popped after each edge.
module tb_mod_counter;

   localparam int W = 6;
   localparam int M = 60;

   logic         clk = 1'b0;
   logic         rst, en, ld, up, clr;
   logic [W-1:0] data;
   logic [W-1:0] cnt_w, cnt_s;
   logic         tc_w, tc_s, ro_w, ro_s;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int cnt;
      bit roll;
   } exp_t;

   exp_t sb[$];
   int   m_cnt [2];
   bit   m_roll[2];
   bit   m_valid = 1'b0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(0)) u_wrap (
      .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .Up(up), .Data(data),
      .ClearFlag(clr), .Count(cnt_w), .TermCount(tc_w), .Rollover(ro_w)
   );

   mod_counter #(.WIDTH(W), .MODULUS(M), .SATURATE(1)) u_sat (
      .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .Up(up), .Data(data),
      .ClearFlag(clr), .Count(cnt_s), .TermCount(tc_s), .Rollover(ro_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, check TermCount, push model results, clock, pop and compare.
   task automatic step(input bit r, input bit l, input bit e, input bit u, input bit c,
                       input logic [W-1:0] d);
      rst = r; ld = l; en = e; up = u; clr = c; data = d;
      #1;
      if (m_valid) begin
         chk("tc_wrap", 32'(tc_w), 32'(e & ~l & ~r & ((u & m_cnt[0] == M-1) | (~u & m_cnt[0] == 0))));
         chk("tc_sat",  32'(tc_s), 32'(e & ~l & ~r & ((u & m_cnt[1] == M-1) | (~u & m_cnt[1] == 0))));
      end
      for (int i = 0; i < 2; i++) begin
         int c_n;
         bit r_n, lim;
         c_n = m_cnt[i];
         r_n = m_roll[i];
         lim = 1'b0;
         if (r) begin
            c_n = 0;
            r_n = 1'b0;
         end else if (l) begin
            c_n = (int'(d) < M) ? int'(d) : M-1;
         end else begin
            if (e && u) begin
               if (c_n == M-1) begin lim = 1'b1; c_n = (i == 1) ? M-1 : 0; end
               else c_n = c_n + 1;
            end else if (e && !u) begin
               if (c_n == 0) begin lim = 1'b1; c_n = (i == 1) ? 0 : M-1; end
               else c_n = c_n - 1;
            end
            if (lim)    r_n = 1'b1;
            else if (c) r_n = 1'b0;
         end
         m_cnt[i]  = c_n;
         m_roll[i] = r_n;
         sb.push_back('{cnt: c_n, roll: r_n});
      end
      if (!m_valid && r) m_valid = 1'b1;
      @(posedge clk);
      #1;
      if (m_valid) begin
         exp_t ew, es;
         ew = sb.pop_front();
         es = sb.pop_front();
         chk("cnt_wrap",  32'(cnt_w), 32'(ew.cnt));
         chk("roll_wrap", 32'(ro_w),  32'(ew.roll));
         chk("cnt_sat",   32'(cnt_s), 32'(es.cnt));
         chk("roll_sat",  32'(ro_s),  32'(es.roll));
      end else begin
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; data = 6'd17;
      m_cnt = '{0, 0};
      m_roll = '{1'b0, 1'b0};
      @(negedge clk);

      // Reset overrides Load and Enable.
      for (int k = 0; k < 2; k++) begin
         step(1, 1, 1, 1, 0, 6'd17);
         chk("rst_cnt", 32'(cnt_w), 0);
         chk("rst_roll", 32'(ro_w), 0);
         chk("rst_tc", 32'(tc_w), 0);
      end

      // Upper limit: wrap vs hold.
      step(0, 1, 0, 1, 0, 6'd58);
      step(0, 0, 1, 1, 0, 6'd0);
      chk("up1_wrap", 32'(cnt_w), 59);
      chk("up1_roll", 32'(ro_w), 0);
      #3 chk("tc_at_59", 32'(tc_w), 1);
      step(0, 0, 1, 1, 0, 6'd0);
      chk("up2_wrap", 32'(cnt_w), 0);
      chk("up2_sat", 32'(cnt_s), 59);
      chk("up2_roll_sat", 32'(ro_s), 1);
      step(0, 0, 1, 1, 0, 6'd0);
      chk("up3_wrap", 32'(cnt_w), 1);
      chk("up3_sat", 32'(cnt_s), 59);
      chk("up3_roll_wrap", 32'(ro_w), 1);

      // Clear, then lower limit.
      step(0, 0, 0, 1, 1, 6'd0);
      chk("clr_roll", 32'(ro_w), 0);
      step(0, 1, 0, 0, 0, 6'd0);
      step(0, 0, 1, 0, 0, 6'd0);
      chk("dn_wrap", 32'(cnt_w), 59);
      chk("dn_sat", 32'(cnt_s), 0);
      chk("dn_roll_sat", 32'(ro_s), 1);

      // Clamp and Load priority over Enable.
      step(0, 1, 0, 1, 0, 6'd63);
      chk("clamp", 32'(cnt_w), 59);
      step(0, 1, 1, 1, 0, 6'd5);
      chk("ld_en", 32'(cnt_s), 5);

      // ClearFlag on the wrap edge: set wins.
      step(0, 1, 0, 1, 0, 6'd59);
      step(0, 0, 1, 1, 1, 6'd0);
      chk("clr_wrap_roll", 32'(ro_w), 1);
      step(0, 0, 0, 1, 1, 6'd0);
      chk("clr_after_roll", 32'(ro_w), 0);

      // Direction change, hold, and reset mid-count.
      step(0, 1, 0, 1, 0, 6'd10);
      step(0, 0, 1, 1, 0, 6'd0);
      step(0, 0, 1, 0, 0, 6'd0);
      chk("dir_change", 32'(cnt_w), 10);
      step(0, 0, 0, 0, 0, 6'd0);
      chk("hold", 32'(cnt_w), 10);
      step(1, 0, 1, 1, 0, 6'd0);
      step(0, 0, 1, 1, 0, 6'd0);
      chk("resume", 32'(cnt_w), 1);

      // Random traffic against the model.
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0), W'($urandom_range(0, 63)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
